// File: rtl/dac_stream_scheduler.sv
// Paces the DAC sample stream: one beat per programmable period, sourced from
// DDS (s0) or DMA (s1), with source switches held off until a frame boundary.
module dac_stream_scheduler #(
  parameter int DATA_W = 8,
  parameter int DIV_W  = 16
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              enable,
  input  logic [DIV_W-1:0]  rate_div,
  input  logic              src_sel,
  input  logic              clr_stats,
  input  logic [DATA_W-1:0] s0_axis_tdata,
  input  logic              s0_axis_tvalid,
  input  logic              s0_axis_tlast,
  output logic              s0_axis_tready,
  input  logic [DATA_W-1:0] s1_axis_tdata,
  input  logic              s1_axis_tvalid,
  input  logic              s1_axis_tlast,
  output logic              s1_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              active_src,
  output logic              switch_pending,
  output logic [DIV_W-1:0]  underrun_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, PEND} state_t;

  state_t             state_q, state_d;
  logic               active_q, active_d;
  logic [DIV_W-1:0]   cnt_q, period_q, urc_q;
  logic [DATA_W-1:0]  last_q;
  logic               mvld_q;

  logic               running, tick, busy, fetch, take, underrun;
  logic               src_valid, src_last;
  logic [DATA_W-1:0]  src_data;

  assign running   = (state_q != IDLE);
  assign tick      = running && enable && (cnt_q == period_q);
  // A beat still waiting on the DAC stage swallows the tick entirely.
  assign busy      = mvld_q && !m_axis_tready;
  assign fetch     = tick && !busy;

  assign src_valid = active_q ? s1_axis_tvalid : s0_axis_tvalid;
  assign src_last  = active_q ? s1_axis_tlast  : s0_axis_tlast;
  assign src_data  = active_q ? s1_axis_tdata  : s0_axis_tdata;

  assign take      = fetch && src_valid;
  assign underrun  = fetch && !src_valid;

  assign s0_axis_tready = take && !active_q;
  assign s1_axis_tready = take &&  active_q;

  assign m_axis_tdata   = last_q;
  assign m_axis_tvalid  = mvld_q;
  assign active_src     = active_q;
  assign switch_pending = running && (src_sel != active_q);
  assign underrun_cnt   = urc_q;

  always_comb begin
    state_d  = state_q;
    active_d = active_q;
    case (state_q)
      IDLE: if (enable) begin
        state_d  = RUN;
        active_d = src_sel;
      end
      RUN: begin
        if (!enable)                  state_d = IDLE;
        else if (src_sel != active_q) state_d = PEND;
      end
      PEND: begin
        if (!enable)                  state_d = IDLE;
        else if (src_sel == active_q) state_d = RUN;
        else if ((take && src_last) || underrun) begin
          // Frame boundary (or a starved source): hand over to the new source.
          active_d = src_sel;
          state_d  = RUN;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q  <= IDLE;
      active_q <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      urc_q    <= '0;
      last_q   <= '0;
      mvld_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      active_q <= active_d;

      // Period is latched only at reload so mid-period rate changes are clean.
      if (!running || cnt_q == period_q) begin
        cnt_q    <= '0;
        period_q <= rate_div;
      end else begin
        cnt_q    <= cnt_q + DIV_W'(1);
      end

      if (fetch)              mvld_q <= 1'b1;
      else if (m_axis_tready) mvld_q <= 1'b0;

      if (take) last_q <= src_data;

      if (clr_stats)                      urc_q <= '0;
      else if (underrun && urc_q != '1)   urc_q <= urc_q + DIV_W'(1);
    end
  end

endmodule

// File: tb/tb_dac_stream_scheduler.sv
// Directed bench for dac_stream_scheduler: pacing, underrun, frame switch,
// backpressure, mid-operation reset and counter saturation.
module tb_dac_stream_scheduler;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        enable;
  logic [15:0] rate_div;
  logic        src_sel;
  logic        clr_stats;
  logic [7:0]  s0_axis_tdata;
  logic        s0_axis_tvalid;
  logic        s0_axis_tlast;
  logic        s0_axis_tready;
  logic [7:0]  s1_axis_tdata;
  logic        s1_axis_tvalid;
  logic        s1_axis_tlast;
  logic        s1_axis_tready;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        active_src;
  logic        switch_pending;
  logic [15:0] underrun_cnt;

  int total = 0;
  int bad   = 0;

  always #5 aclk = ~aclk;

  dac_stream_scheduler #(.DATA_W(8), .DIV_W(16)) dut (
    .aclk(aclk), .aresetn(aresetn), .enable(enable), .rate_div(rate_div),
    .src_sel(src_sel), .clr_stats(clr_stats),
    .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
    .s0_axis_tlast(s0_axis_tlast), .s0_axis_tready(s0_axis_tready),
    .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
    .s1_axis_tlast(s1_axis_tlast), .s1_axis_tready(s1_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .active_src(active_src),
    .switch_pending(switch_pending), .underrun_cnt(underrun_cnt)
  );

  task automatic do_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0; enable = 1'b0; rate_div = 16'd0; src_sel = 1'b0; clr_stats = 1'b0;
    s0_axis_tdata = 8'h00; s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    s1_axis_tdata = 8'h00; s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge aclk);
    total++; if (m_axis_tvalid !== 1'b0) begin bad++; $display("FAIL reset_tvalid got=%b want=0", m_axis_tvalid); end
    total++; if (m_axis_tdata !== 8'h00) begin bad++; $display("FAIL reset_tdata got=%h want=00", m_axis_tdata); end
    total++; if ({active_src, switch_pending} !== 2'b00) begin bad++; $display("FAIL reset_src got=%b want=00", {active_src, switch_pending}); end
    total++; if (underrun_cnt !== 16'h0) begin bad++; $display("FAIL reset_urc got=%h want=0000", underrun_cnt); end
    total++; if ({s0_axis_tready, s1_axis_tready} !== 2'b00) begin bad++; $display("FAIL reset_treadys got=%b want=00", {s0_axis_tready, s1_axis_tready}); end
  endtask

  task automatic test_stream();
    logic [7:0] idx = 8'h00;
    logic       hs = 1'b0;
    logic [7:0] ed;
    do_reset();
    rate_div = 16'd3; s0_axis_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge aclk); #1;
      if (hs) idx++;
      s0_axis_tdata = 8'h10 + idx; enable = 1'b1;
      @(negedge aclk);
      hs = s0_axis_tready && s0_axis_tvalid;
      total++;
      if (s0_axis_tready !== (i >= 4 && i % 4 == 0)) begin bad++; $display("FAIL stream_s0_tready cyc=%0d got=%b", i, s0_axis_tready); end
      total++;
      if (m_axis_tvalid !== (i >= 5 && i % 4 == 1)) begin bad++; $display("FAIL stream_tvalid cyc=%0d got=%b", i, m_axis_tvalid); end
      if (i >= 5 && i % 4 == 1) begin
        ed = 8'h10 + 8'((i - 5) / 4);
        total++;
        if (m_axis_tdata !== ed) begin bad++; $display("FAIL stream_tdata cyc=%0d got=%h want=%h", i, m_axis_tdata, ed); end
      end
    end
  endtask

  task automatic test_underrun();
    int n55 = 0;
    logic [7:0] ed;
    do_reset();
    rate_div = 16'd0;
    for (int i = 0; i < 8; i++) begin
      @(posedge aclk); #1;
      enable = 1'b1;
      s0_axis_tvalid = !(i >= 2 && i <= 4) && (i != 6);
      s0_axis_tdata  = (i >= 5) ? 8'h66 : 8'h55;
      clr_stats      = (i == 6);
      @(negedge aclk);
      if (m_axis_tvalid && m_axis_tdata == 8'h55) n55++;
      if (i >= 2) begin
        ed = (i <= 5) ? 8'h55 : 8'h66;
        total++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, ed}) begin bad++; $display("FAIL underrun_beat cyc=%0d got=%b/%h want=1/%h", i, m_axis_tvalid, m_axis_tdata, ed); end
      end
      if (i == 5 || i == 6) begin
        total++;
        if (underrun_cnt !== 16'd3) begin bad++; $display("FAIL underrun_cnt3 cyc=%0d got=%0d want=3", i, underrun_cnt); end
      end
      if (i == 7) begin
        total++;
        if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL underrun_clr_wins got=%0d want=0", underrun_cnt); end
      end
    end
    clr_stats = 1'b0;
    total++;
    if (n55 != 4) begin bad++; $display("FAIL underrun_repeat_count got=%0d want=4", n55); end
  endtask

  task automatic test_switch();
    logic [7:0] idx = 8'h00;
    logic       hs = 1'b0;
    do_reset();
    s0_axis_tvalid = 1'b1; s1_axis_tvalid = 1'b1; s1_axis_tdata = 8'hB0;
    for (int i = 0; i < 6; i++) begin
      @(posedge aclk); #1;
      if (hs) idx++;
      s0_axis_tdata = 8'hA0 + idx; s0_axis_tlast = (idx == 8'd2);
      enable = 1'b1; src_sel = (i >= 2);
      @(negedge aclk);
      hs = s0_axis_tready && s0_axis_tvalid;
      if (i == 2 || i == 3) begin
        total++;
        if (switch_pending !== 1'b1) begin bad++; $display("FAIL switch_pending_hi cyc=%0d got=%b", i, switch_pending); end
      end
      if (i == 3) begin
        total++;
        if (m_axis_tdata !== 8'hA1 || active_src !== 1'b0) begin bad++; $display("FAIL switch_still_s0 got=%h/%b want=a1/0", m_axis_tdata, active_src); end
      end
      if (i == 4) begin
        total++;
        if ({switch_pending, active_src} !== 2'b01) begin bad++; $display("FAIL switch_done got=%b want=01", {switch_pending, active_src}); end
        total++;
        if ({s1_axis_tready, s0_axis_tready} !== 2'b10) begin bad++; $display("FAIL switch_treadys got=%b want=10", {s1_axis_tready, s0_axis_tready}); end
        total++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'hA2}) begin bad++; $display("FAIL switch_last_s0 got=%h want=a2", m_axis_tdata); end
      end
      if (i == 5) begin
        total++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'hB0}) begin bad++; $display("FAIL switch_first_s1 got=%h want=b0", m_axis_tdata); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] idx = 8'h00;
    logic       hs = 1'b0;
    do_reset();
    rate_div = 16'd1; s0_axis_tvalid = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(posedge aclk); #1;
      if (hs) idx++;
      s0_axis_tdata = 8'h30 + idx; enable = 1'b1;
      m_axis_tready = !(i >= 3 && i <= 12);
      @(negedge aclk);
      hs = s0_axis_tready && s0_axis_tvalid;
      if (i >= 3 && i <= 13) begin
        total++;
        if ({m_axis_tvalid, m_axis_tdata, s0_axis_tready} !== {1'b1, 8'h30, 1'b0}) begin
          bad++; $display("FAIL bp_hold cyc=%0d got=%b/%h/%b want=1/30/0", i, m_axis_tvalid, m_axis_tdata, s0_axis_tready);
        end
      end
      if (i == 14) begin
        total++;
        if ({m_axis_tvalid, s0_axis_tready} !== 2'b01) begin bad++; $display("FAIL bp_release got=%b want=01", {m_axis_tvalid, s0_axis_tready}); end
      end
      if (i == 15) begin
        total++;
        if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'h31}) begin bad++; $display("FAIL bp_next got=%h want=31", m_axis_tdata); end
      end
    end
    total++;
    if (underrun_cnt !== 16'd0) begin bad++; $display("FAIL bp_no_underrun got=%0d want=0", underrun_cnt); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    s0_axis_tvalid = 1'b1; s0_axis_tdata = 8'h77;
    for (int i = 0; i < 8; i++) begin
      @(posedge aclk); #1;
      enable = 1'b1; src_sel = (i >= 2); aresetn = (i != 4);
      m_axis_tready = 1'b0;
      @(negedge aclk);
      if (i == 3) begin
        total++;
        if ({switch_pending, m_axis_tvalid, m_axis_tdata} !== {2'b11, 8'h77}) begin
          bad++; $display("FAIL mid_pend got=%b/%b/%h want=1/1/77", switch_pending, m_axis_tvalid, m_axis_tdata);
        end
      end
      if (i == 5) begin
        total++;
        if ({m_axis_tvalid, m_axis_tdata, active_src, switch_pending, s0_axis_tready, s1_axis_tready, underrun_cnt} !== 29'd0) begin
          bad++; $display("FAIL mid_reset_outputs got=%b/%h/%b/%b/%b/%b/%h want=all 0", m_axis_tvalid, m_axis_tdata,
                          active_src, switch_pending, s0_axis_tready, s1_axis_tready, underrun_cnt);
        end
      end
      if (i == 7) begin
        total++;
        if ({m_axis_tvalid, m_axis_tdata, active_src, underrun_cnt} !== {1'b1, 8'h00, 1'b1, 16'd1}) begin
          bad++; $display("FAIL mid_restart got=%b/%h/%b/%0d want=1/00/1/1", m_axis_tvalid, m_axis_tdata, active_src, underrun_cnt);
        end
      end
    end
    m_axis_tready = 1'b1;
  endtask

  task automatic test_saturate();
    do_reset();
    @(posedge aclk); #1;
    enable = 1'b1;
    repeat (65535) @(posedge aclk);
    @(negedge aclk);
    total++;
    if (underrun_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h want=fffe", underrun_cnt); end
    for (int k = 0; k < 3; k++) begin
      @(negedge aclk);
      total++;
      if (underrun_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold k=%0d got=%h want=ffff", k, underrun_cnt); end
    end
    total++;
    if ({m_axis_tvalid, m_axis_tdata} !== {1'b1, 8'h00}) begin bad++; $display("FAIL sat_repeat got=%b/%h want=1/00", m_axis_tvalid, m_axis_tdata); end
  endtask

  initial begin
    aresetn = 1'b0; enable = 1'b0; rate_div = 16'd0; src_sel = 1'b0; clr_stats = 1'b0;
    s0_axis_tdata = 8'h00; s0_axis_tvalid = 1'b0; s0_axis_tlast = 1'b0;
    s1_axis_tdata = 8'h00; s1_axis_tvalid = 1'b0; s1_axis_tlast = 1'b0;
    m_axis_tready = 1'b1;
    test_reset();
    test_stream();
    test_underrun();
    test_switch();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dac_stream_scheduler.md
Name: dac_stream_scheduler

Overview:
- Paces and sources the 8-bit sample stream that feeds the DAC output stage.
- Selects one of two AXI4-Stream sources: s0 is the DDS generator and s1 is the DMA waveform buffer. Source switches happen only at frame boundaries.
- Emits exactly one sample per programmable sample period as a single m_axis_tvalid beat. Because the DAC stage gates its DAC_CLK with tvalid, each beat produces one DAC clock.
- On underrun, repeats the last sample and counts the event.

Parameters:
- DATA_W, 8, sample width on all streams.
- DIV_W, 16, width of the sample-period divider and of the underrun counter.

Ports:
- aclk  in  1  clock
- aresetn  in  1  synchronous, active-low reset
- enable  in  1  run/stop playback
- rate_div  in  DIV_W  sample period in aclk cycles, minus 1
- src_sel  in  1  requested source (0=s0, 1=s1)
- clr_stats  in  1  one-cycle pulse that clears underrun_cnt
- s0_axis_tdata / s0_axis_tvalid / s0_axis_tlast  in  DATA_W/1/1  source 0 stream
- s0_axis_tready  out  1
- s1_axis_tdata / s1_axis_tvalid / s1_axis_tlast  in  DATA_W/1/1  source 1 stream
- s1_axis_tready  out  1
- m_axis_tdata  out  DATA_W  sample to the DAC stage
- m_axis_tvalid  out  1
- m_axis_tready  in  1
- active_src  out  1  source currently being played
- switch_pending  out  1  src_sel differs from active_src and is waiting for a frame boundary
- underrun_cnt  out  DIV_W  saturating underrun count

Behaviour:
- Reset (aresetn=0 at a clock edge):
  - Outputs: all outputs 0.
  - Internal state: state=IDLE, tick counter=0, last-sample register=0.
  - Reset mid-frame discards any pending beat.
- Tick counter:
  - Runs only in RUN/PEND.
  - Counts 0..rate_div; tick=1 in the cycle count==rate_div, and count reloads to 0.
  - rate_div is sampled only at reload, so a mid-period change takes effect next period.
  - rate_div=0 gives a tick every cycle.
- Output handshake:
  - m_axis_tvalid rises the cycle after a tick and stays high until m_axis_tready=1. m_axis_tdata is stable while tvalid=1.
  - Ticks occurring while a beat is still pending are skipped: no fetch, no underrun count.
- Fetch on tick (output not pending):
  - If the active source has tvalid=1: assert its tready combinationally in the tick cycle only, capture tdata into the last-sample register, and present it on m_axis_tdata with tvalid=1 the next cycle. Latency is tick -> output = 1 cycle.
  - If the active source has tvalid=0: underrun. Re-present the last-sample register with tvalid=1, and increment underrun_cnt (saturates at 2^DIV_W-1).
- The inactive source's tready is always 0. Both treadys are 0 outside ticks.
- clr_stats: clears underrun_cnt. If it coincides with an underrun, clear wins (result 0).
- FSM:
  - IDLE:
    - Treadys 0 and counter held at 0.
    - m_axis_tdata holds its last value.
    - m_axis_tvalid stays 0 once any pending beat completes.
    - enable=1 -> RUN; active_src<=src_sel; the first tick comes rate_div+1 cycles later.
  - RUN:
    - src_sel!=active_src -> PEND (switch_pending=1).
    - enable=0 -> IDLE.
  - PEND:
    - Keep playing the current source.
    - On an accepted beat with tlast=1, or on an underrun tick: active_src<=src_sel the next cycle, then -> RUN.
    - src_sel returning to active_src -> RUN with no switch.
    - enable=0 -> IDLE, switch abandoned.
- Disable with a beat pending: the beat still completes its handshake before m_axis_tvalid drops; no new fetches.

Test Plan:
- rate_div=3, s0 streaming 0x10,0x11,0x12... with tvalid=1, m_axis_tready=1 -> m_axis_tvalid pulses once every 4 cycles; data 0x10,0x11,0x12 in order; s0_axis_tready pulses in the cycle before each tvalid.
- rate_div=0, s0 tvalid drops for 3 consecutive ticks after sample 0x55 -> 0x55 is output 4 times in total; underrun_cnt=3. Then clr_stats coincides with a 4th underrun -> underrun_cnt=0.
- Frame switch: src_sel 0->1 mid-frame; s0 beats 0xA0,0xA1,0xA2(tlast) -> 0xA2 is the last s0 sample; the next tick takes s1 data; active_src=1; switch_pending is high from the src_sel change until the switch.
- Backpressure: m_axis_tready=0 for 10 cycles with rate_div=1 -> tdata held; intermediate ticks fetch nothing (s0 tready stays 0, underrun_cnt unchanged); one beat completes when tready=1.
- Reset mid-operation: aresetn=0 for one cycle while in PEND with a pending beat -> next cycle all outputs 0, state IDLE; enable=1 restarts from s<src_sel> with last-sample=0.
- underrun_cnt at 0xFFFE followed by 3 underruns -> saturates at 0xFFFF.
